// File: rtl/ddr_req_gen.sv
// Request/address generator feeding the DDR scheduler: holds one pixel word for writing,
// tracks write/read positions across a ring of frame buffers, and forms the DDR app address.
module ddr_req_gen #(
  parameter int NUM_FRAMES   = 4,
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 128,
  parameter int FRAME_WORDS  = 76800,
  parameter int WORD_STRIDE  = 8,
  parameter int FRAME_STRIDE = 1048576,
  localparam int BUF_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
  localparam int CNT_W = OFF_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  rd_enable,
  input  logic                  rd_space_ok,
  output logic                  w_req,
  output logic                  r_req,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [2:0]            cmd,
  input  logic                  wr_cmd_sent,
  input  logic                  rd_cmd_sent,
  input  logic [BUF_W-1:0]      rd_addr_num,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  primed,
  output logic                  wr_frame_done
);

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(FRAME_WORDS - 1);
  localparam logic [BUF_W-1:0] BUF_LAST = BUF_W'(NUM_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_WORDS);
  localparam logic [BUF_W:0]   SLOT_N   = (BUF_W + 1)'(NUM_FRAMES);

  function automatic logic [ADDR_WIDTH-1:0] frame_addr(input logic [BUF_W:0]   buf_idx,
                                                       input logic [OFF_W-1:0] off);
    return ADDR_WIDTH'(buf_idx) * ADDR_WIDTH'(FRAME_STRIDE)
         + ADDR_WIDTH'(off) * ADDR_WIDTH'(WORD_STRIDE);
  endfunction

  function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] cur);
    return (cur == BUF_LAST) ? '0 : cur + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  w_req_q, w_req_d;
  logic                  r_req_q, r_req_d;
  logic                  primed_q, primed_d;
  logic                  wr_frame_done_q, wr_frame_done_d;
  logic [BUF_W-1:0]      wr_buf_q, wr_buf_d;
  logic [OFF_W-1:0]      wr_offset_q, wr_offset_d;
  logic [BUF_W-1:0]      rd_buf_q, rd_buf_d;
  logic [OFF_W-1:0]      rd_offset_q, rd_offset_d;
  logic [CNT_W-1:0]      ahead_cnt_q, ahead_cnt_d;

  logic                  load;
  logic                  wr_inc;
  logic                  rd_dec;
  logic [BUF_W:0]        rd_slot_sum;
  logic [BUF_W:0]        rd_slot;

  // A full ahead count means the next write would land on the oldest unread word.
  assign in_ready = (!hold_valid_q | wr_cmd_sent) & (ahead_cnt_q != CNT_FULL);
  assign load     = in_valid & in_ready;

  always_comb begin
    wr_data_d       = wr_data_q;
    hold_valid_d    = hold_valid_q;
    primed_d        = primed_q;
    wr_frame_done_d = 1'b0;
    wr_buf_d        = wr_buf_q;
    wr_offset_d     = wr_offset_q;
    rd_buf_d        = rd_buf_q;
    rd_offset_d     = rd_offset_q;
    ahead_cnt_d     = ahead_cnt_q;

    if (wr_cmd_sent) begin
      hold_valid_d = 1'b0;
      if (wr_offset_q == OFF_LAST) begin
        wr_offset_d     = '0;
        wr_buf_d        = next_buf(wr_buf_q);
        wr_frame_done_d = 1'b1;
        if (next_buf(wr_buf_q) == BUF_LAST) primed_d = 1'b1;
      end else begin
        wr_offset_d = wr_offset_q + 1'b1;
      end
    end

    if (load) begin
      wr_data_d    = in_data;
      hold_valid_d = 1'b1;
    end

    if (rd_cmd_sent) begin
      if (rd_offset_q == OFF_LAST) begin
        rd_offset_d = '0;
        rd_buf_d    = next_buf(rd_buf_q);
      end else begin
        rd_offset_d = rd_offset_q + 1'b1;
      end
    end

    // Writes only count against the reader once the ring holds NUM_FRAMES-1 full frames.
    wr_inc = wr_cmd_sent & primed_q & (ahead_cnt_q != CNT_FULL);
    rd_dec = rd_cmd_sent & (ahead_cnt_q != '0);
    if (wr_inc && !rd_dec) ahead_cnt_d = ahead_cnt_q + 1'b1;
    else if (rd_dec && !wr_inc) ahead_cnt_d = ahead_cnt_q - 1'b1;

    w_req_d = hold_valid_d & (ahead_cnt_d != CNT_FULL);
    r_req_d = primed_d & rd_enable & rd_space_ok & (ahead_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_data_q       <= '0;
      hold_valid_q    <= 1'b0;
      w_req_q         <= 1'b0;
      r_req_q         <= 1'b0;
      primed_q        <= 1'b0;
      wr_frame_done_q <= 1'b0;
      wr_buf_q        <= '0;
      wr_offset_q     <= '0;
      rd_buf_q        <= '0;
      rd_offset_q     <= '0;
      ahead_cnt_q     <= '0;
    end else begin
      wr_data_q       <= wr_data_d;
      hold_valid_q    <= hold_valid_d;
      w_req_q         <= w_req_d;
      r_req_q         <= r_req_d;
      primed_q        <= primed_d;
      wr_frame_done_q <= wr_frame_done_d;
      wr_buf_q        <= wr_buf_d;
      wr_offset_q     <= wr_offset_d;
      rd_buf_q        <= rd_buf_d;
      rd_offset_q     <= rd_offset_d;
      ahead_cnt_q     <= ahead_cnt_d;
    end
  end

  // Slot 0 is the oldest frame; later slots walk forward around the ring.
  always_comb begin
    rd_slot_sum = {1'b0, rd_buf_q} + {1'b0, rd_addr_num};
    rd_slot     = (rd_slot_sum >= SLOT_N) ? rd_slot_sum - SLOT_N : rd_slot_sum;
    mem_addr    = (cmd == 3'b001) ? frame_addr(rd_slot, rd_offset_q)
                                  : frame_addr({1'b0, wr_buf_q}, wr_offset_q);
  end

  assign wr_data       = wr_data_q;
  assign w_req         = w_req_q;
  assign r_req         = r_req_q;
  assign primed        = primed_q;
  assign wr_frame_done = wr_frame_done_q;

endmodule

// File: tb/tb_ddr_req_gen.sv
// Directed bench for ddr_req_gen with a 4-frame ring of 16-word frames; the bench plays the scheduler.
module tb_ddr_req_gen;

  localparam int NF = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int FW = 16;
  localparam int FS = 1048576;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          rd_enable;
  logic          rd_space_ok;
  logic          w_req;
  logic          r_req;
  logic [DW-1:0] wr_data;
  logic [2:0]    cmd;
  logic          wr_cmd_sent;
  logic          rd_cmd_sent;
  logic [1:0]    rd_addr_num;
  logic [AW-1:0] mem_addr;
  logic          primed;
  logic          wr_frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  ddr_req_gen #(
    .NUM_FRAMES(NF), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAME_WORDS(FW), .WORD_STRIDE(8), .FRAME_STRIDE(FS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_enable(rd_enable), .rd_space_ok(rd_space_ok), .w_req(w_req), .r_req(r_req),
    .wr_data(wr_data), .cmd(cmd), .wr_cmd_sent(wr_cmd_sent), .rd_cmd_sent(rd_cmd_sent),
    .rd_addr_num(rd_addr_num), .mem_addr(mem_addr), .primed(primed),
    .wr_frame_done(wr_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_wr();
    wr_cmd_sent = 1'b1;
    tick();
    wr_cmd_sent = 1'b0;
  endtask

  task automatic send_rd();
    rd_cmd_sent = 1'b1;
    tick();
    rd_cmd_sent = 1'b0;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    load_word(d);
    send_wr();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rd_enable = 1'b1; rd_space_ok = 1'b1;
    cmd = 3'b000; wr_cmd_sent = 1'b0; rd_cmd_sent = 1'b0; rd_addr_num = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", DW'(in_ready), 1);
    check("rst_w_req", DW'(w_req), 0);
    check("rst_r_req", DW'(r_req), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_primed", DW'(primed), 0);
    check("rst_frame_done", DW'(wr_frame_done), 0);
    check("rst_waddr", DW'(mem_addr), 0);

    // First frame: addresses step by the word stride.
    for (int i = 0; i < FW; i++) begin
      load_word(DW'(i + 1));
      check($sformatf("w_req_%0d", i), DW'(w_req), 1);
      check($sformatf("waddr_%0d", i), DW'(mem_addr), DW'(i * 8));
      send_wr();
    end
    check("frame_done_pulse", DW'(wr_frame_done), 1);
    check("primed_after_f0", DW'(primed), 0);
    check("waddr_buf1", DW'(mem_addr), DW'(FS));
    check("wr_data_last", wr_data, DW'(16));
    check("w_req_idle", DW'(w_req), 0);
    tick();
    check("frame_done_clear", DW'(wr_frame_done), 0);

    // Frames 1 and 2 complete the priming.
    for (int i = 17; i <= 48; i++) write_word(DW'(i));
    check("primed_set", DW'(primed), 1);
    check("r_req_at_prime", DW'(r_req), 0);
    check("waddr_buf3", DW'(mem_addr), DW'(3 * FS));
    tick();
    check("r_req_still_0", DW'(r_req), 0);

    load_word(DW'(49));
    check("r_req_before_49", DW'(r_req), 0);
    send_wr();
    check("r_req_after_49", DW'(r_req), 1);

    // First read set: oldest frame first at offset 0.
    cmd = 3'b001;
    for (int n = 0; n < NF; n++) begin
      rd_addr_num = 2'(n);
      #1;
      check($sformatf("raddr_slot%0d", n), DW'(mem_addr), DW'(n * FS));
    end
    send_rd();
    check("r_req_drained", DW'(r_req), 0);
    rd_addr_num = 2'd0;
    #1;
    check("raddr_off1", DW'(mem_addr), DW'(8));
    cmd = 3'b000;

    // Writes run a full frame ahead of reads and stall.
    rd_enable = 1'b0;
    for (int i = 0; i < FW; i++) write_word(DW'(100 + i));
    check("stall_in_ready", DW'(in_ready), 0);
    check("stall_w_req", DW'(w_req), 0);
    check("stall_r_req", DW'(r_req), 0);
    check("stall_waddr", DW'(mem_addr), DW'(8));

    rd_enable = 1'b1;
    tick();
    check("r_req_reenabled", DW'(r_req), 1);
    cmd = 3'b001;
    rd_addr_num = 2'd2;
    #1;
    check("raddr_slot2_off1", DW'(mem_addr), DW'(2 * FS + 8));
    send_rd();
    cmd = 3'b000;
    check("unstall_in_ready", DW'(in_ready), 1);
    check("r_req_ahead15", DW'(r_req), 1);

    // Held word that would overrun the reader waits with w_req low.
    rd_enable = 1'b0;
    load_word(DW'(200));
    check("w_req_word_c", DW'(w_req), 1);
    wr_cmd_sent = 1'b1;
    in_valid = 1'b1;
    in_data = DW'(201);
    #1;
    check("in_ready_with_sent", DW'(in_ready), 1);
    tick();
    wr_cmd_sent = 1'b0;
    in_valid = 1'b0;
    check("held_w_req_low", DW'(w_req), 0);
    check("held_in_ready", DW'(in_ready), 0);
    check("held_wr_data", wr_data, DW'(201));
    check("held_waddr", DW'(mem_addr), DW'(16));
    rd_enable = 1'b1;
    tick();
    check("r_req_for_held", DW'(r_req), 1);
    send_rd();
    check("held_w_req_high", DW'(w_req), 1);
    send_wr();
    check("full_again_in_ready", DW'(in_ready), 0);
    check("full_again_w_req", DW'(w_req), 0);

    // Finish the read frame: 16 read sets in total moves the reader to buffer 1.
    repeat (13) send_rd();
    check("r_req_ahead3", DW'(r_req), 1);
    cmd = 3'b001;
    for (int n = 0; n < NF; n++) begin
      rd_addr_num = 2'(n);
      #1;
      check($sformatf("raddr_wrap_slot%0d", n), DW'(mem_addr), DW'(((1 + n) % NF) * FS));
    end
    cmd = 3'b000;
    rd_addr_num = 2'd0;

    // Reset in the middle of operation.
    rd_enable = 1'b0;
    write_word(DW'(300));
    write_word(DW'(301));
    rd_enable = 1'b1;
    load_word(DW'(302));
    check("pre_rst_w_req", DW'(w_req), 1);
    check("pre_rst_r_req", DW'(r_req), 1);
    check("pre_rst_waddr", DW'(mem_addr), DW'(40));
    rst = 1'b1;
    tick();
    check("midrst_w_req", DW'(w_req), 0);
    check("midrst_r_req", DW'(r_req), 0);
    check("midrst_primed", DW'(primed), 0);
    check("midrst_in_ready", DW'(in_ready), 1);
    check("midrst_waddr", DW'(mem_addr), 0);
    check("midrst_wr_data", wr_data, 0);
    rst = 1'b0;
    tick();
    check("post_rst_r_req", DW'(r_req), 0);
    check("post_rst_w_req", DW'(w_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_req_gen.md
Name: ddr_req_gen

Overview:
- Request/address generator directly upstream of the DDR memory scheduler in the optical-flow frame-buffer path.
- Accepts the incoming pixel-word stream and holds one word at a time for writing.
- Raises write/read requests toward the scheduler and supplies the DDR address for each command the scheduler issues.
- Reads return the same pixel offset from NUM_FRAMES consecutive frame buffers, oldest first, for the temporal-derivative stage.

Parameters:
NUM_FRAMES, 4, frame buffers in ring; words fetched per read set
ADDR_WIDTH, 28, DDR app address width
DATA_WIDTH, 128, DDR word width
FRAME_WORDS, 76800, DDR words per frame
WORD_STRIDE, 8, address increment per DDR word
FRAME_STRIDE, 1048576, address distance between frame buffers (≥ FRAME_WORDS*WORD_STRIDE)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel word valid
in_data  in  DATA_WIDTH  pixel word
in_ready  out  1  block can accept word
rd_enable  in  1  global read enable from top
rd_space_ok  in  1  downstream read FIFO can absorb NUM_FRAMES words
w_req  out  1  write request to scheduler
r_req  out  1  read-set request to scheduler
wr_data  out  DATA_WIDTH  held word for DDR write-data FIFO
cmd  in  3  scheduler command (3'b001 read, 3'b000 write)
wr_cmd_sent  in  1  scheduler accepted write command (1-cycle pulse)
rd_cmd_sent  in  1  scheduler issued final address of read set (1-cycle pulse)
rd_addr_num  in  clog2(NUM_FRAMES)  scheduler read-slot index
mem_addr  out  ADDR_WIDTH  DDR app address
primed  out  1  NUM_FRAMES-1 full frames written; reads legal
wr_frame_done  out  1  pulse: last word of a frame written

Behaviour:
- Reset values: in_ready=1, w_req=0, r_req=0, wr_data=0, primed=0, wr_frame_done=0; internal wr_buf=0, wr_offset=0, rd_buf=0, rd_offset=0, ahead_cnt=0, hold_valid=0.
- Write holding register:
  - in_ready = !hold_valid | wr_cmd_sent, gated low when ahead_cnt == FRAME_WORDS.
  - On in_valid & in_ready: wr_data <= in_data, hold_valid <= 1.
  - w_req = hold_valid, registered.
  - On wr_cmd_sent: hold_valid cleared unless a new word loads the same cycle; wr_offset increments.
- Write wrap:
  - When wr_offset == FRAME_WORDS-1 at wr_cmd_sent: wr_offset <= 0, wr_buf <= (wr_buf+1) mod NUM_FRAMES, wr_frame_done pulses one cycle.
  - The first time wr_buf advances to NUM_FRAMES-1, primed <= 1. primed is sticky until rst.
- Write address: wr_buf*FRAME_STRIDE + wr_offset*WORD_STRIDE, truncated to ADDR_WIDTH.
- ahead_cnt (width clog2(FRAME_WORDS)+1):
  - Increments on wr_cmd_sent while primed; the increment begins on the first write after primed sets.
  - Decrements on rd_cmd_sent.
  - Both in the same cycle: unchanged.
  - Never exceeds FRAME_WORDS (writes stall) and never goes below 0.
- r_req (registered) = primed & rd_enable & rd_space_ok & (ahead_cnt > 0). A read set is thus never issued before the newest frame's word at that offset has been written.
- Read addresses: slot n address = ((rd_buf+n) mod NUM_FRAMES)*FRAME_STRIDE + rd_offset*WORD_STRIDE; slot 0 is the oldest frame.
- Read set completion (rd_cmd_sent):
  - rd_offset increments.
  - At FRAME_WORDS-1: rd_offset <= 0, rd_buf <= (rd_buf+1) mod NUM_FRAMES.
- mem_addr (combinational) = (cmd == 3'b001) ? read address for slot rd_addr_num : write address.
- Overwrite protection: ahead_cnt == FRAME_WORDS means writes would overwrite the oldest unread word, so in_ready and new w_req are held low.
- Reset mid-operation: all counters clear next edge and the held word is discarded; no w_req/r_req the cycle after rst.
- rd_enable or rd_space_ok dropping removes r_req next cycle. A read set already in flight completes.

Test Plan:
- NUM_FRAMES=4, FRAME_WORDS=16: reset, then stream 16 words -> 16 wr_cmd_sent; mem_addr at write = 0,8,...,120; wr_frame_done after 16th; wr_buf=1, primed=0.
- Continue to 48 words written -> primed=1 after 48th, r_req stays 0; 49th write -> ahead_cnt=1, r_req=1 next cycle.
- With r_req high, cmd=001, rd_addr_num 0..3 -> mem_addr = 0, 1048576, 2097152, 3145728; rd_cmd_sent -> ahead_cnt=0, r_req=0, rd_offset=1.
- Stop reads and keep writing -> after 16 writes past primed, ahead_cnt=16, in_ready=0, w_req=0 after held word. One read set -> in_ready returns to 1.
- Read 16 sets -> rd_buf=1; next set addresses = buffers 1,2,3,0 at offset 0.
- Assert rst while hold_valid=1 and ahead_cnt=5 -> next cycle w_req=0, r_req=0, primed=0, in_ready=1, write address 0.
